cfg_frame_ctrl: RTL and testbench

CFG_FRAME_CTRL -- requirements
Module: cfg_frame_ctrl

---
 rtl/cfg_pkg.sv | 32 +++
 rtl/cfg_frame_ctrl_if.sv | 26 ++
 rtl/cfg_frame_fsm.sv | 107 ++++++++++
 rtl/cfg_frame_ctrl.sv | 124 ++++++++++++
 tb/tb_cfg_frame_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the configuration-frame blocks.
//   cfg_state_e : frame-parser states (idle, header address, header opcode, payload, parity)
//   cfg_mode_e  : what this tile does with the current frame once the header is decoded
//   OP_WRITE / OP_READ : opcode bit values carried in the frame header
//   cnt_width() : width of a bit-position counter able to count the longer frame field
package cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrId,
        StHdrOp,
        StPayload,
        StParity
    } cfg_state_e;

    typedef enum logic [1:0] {
        ModeNone,
        ModeWrite,
        ModeRead
    } cfg_mode_e;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned id_width,
                                              input int unsigned cfg_size);
        int unsigned longest;
        longest = (id_width > cfg_size) ? id_width : cfg_size;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/cfg_frame_ctrl_if.sv
// cfg_frame_ctrl_if: serial configuration chain between neighbouring tiles.
//   cfg_in_start / cfg_bit_in   : frame start pulse and serial bit arriving at a tile
//   cfg_out_start / cfg_bit_out : the same, forwarded (or readback data) to the next tile
//   master : the upstream driver; slave : the tile receiving the frame
interface cfg_frame_ctrl_if;

    logic cfg_in_start;
    logic cfg_bit_in;
    logic cfg_out_start;
    logic cfg_bit_out;

    modport master (
        output cfg_in_start,
        output cfg_bit_in,
        input  cfg_out_start,
        input  cfg_bit_out
    );

    modport slave (
        input  cfg_in_start,
        input  cfg_bit_in,
        output cfg_out_start,
        output cfg_bit_out
    );

endinterface

// File: rtl/cfg_frame_fsm.sv
// cfg_frame_fsm: frame parser for one configuration tile.
//   clk, crst_n : clock and asynchronous active-low reset
//   start       : frame start pulse (aborts and restarts any frame in flight)
//   bit_in      : serial frame bit, LSB first
//   state       : current parser state
//   cnt         : bit position within the current field
//   mode        : header decode result, held through payload and parity
module cfg_frame_fsm
    import cfg_pkg::*;
#(
    parameter int unsigned CFG_SIZE = 128,
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned ID       = 7,
    parameter bit          BCAST_EN = 1'b1,
    localparam int unsigned CNT_W   = cnt_width(ID_WIDTH, CFG_SIZE)
) (
    input  logic             clk,
    input  logic             crst_n,
    input  logic             start,
    input  logic             bit_in,
    output cfg_state_e       state,
    output logic [CNT_W-1:0] cnt,
    output cfg_mode_e        mode
);

    cfg_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_WIDTH-1:0] addr_q, addr_d;
    cfg_mode_e           mode_q, mode_d;

    logic id_hit;
    logic bc_hit;

    assign id_hit = (addr_q == ID_WIDTH'(ID));
    assign bc_hit = BCAST_EN && (addr_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        if (start) begin
            state_d = StHdrId;
            cnt_d   = '0;
            addr_d  = '0;
            mode_d  = ModeNone;
        end else begin
            case (state_q)
                StIdle: ;
                StHdrId: begin
                    // LSB arrives first, so shift in from the top
                    addr_d = {bit_in, addr_q[ID_WIDTH-1:1]};
                    if (cnt_q == CNT_W'(ID_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = StHdrOp;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StHdrOp: begin
                    // broadcast only applies to writes; a broadcast readback is ignored
                    if (bit_in == OP_WRITE && (id_hit || bc_hit)) begin
                        mode_d = ModeWrite;
                    end else if (bit_in == OP_READ && id_hit) begin
                        mode_d = ModeRead;
                    end else begin
                        mode_d = ModeNone;
                    end
                    cnt_d   = '0;
                    state_d = StPayload;
                end
                StPayload: begin
                    if (cnt_q == CNT_W'(CFG_SIZE - 1)) begin
                        cnt_d   = '0;
                        state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StParity: begin
                    state_d = StIdle;
                    mode_d  = ModeNone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            mode_q  <= ModeNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
        end
    end

    assign state = state_q;
    assign cnt   = cnt_q;
    assign mode  = mode_q;

endmodule

// File: rtl/cfg_frame_ctrl.sv
// cfg_frame_ctrl: configuration tile on a serial frame chain.
//   clk, crst_n : clock and asynchronous active-low reset
//   chain       : serial in/out chain (slave side); frames are forwarded one cycle later
//   cfg         : active configuration, replaced only by a parity-good write frame
//   cfg_valid   : at least one good write committed since reset
//   cfg_err     : last addressed write frame had bad parity
//   busy        : a frame is being parsed
module cfg_frame_ctrl
    import cfg_pkg::*;
#(
    parameter int unsigned CFG_SIZE = 128,
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned ID       = 7,
    parameter bit          BCAST_EN = 1'b1
) (
    input  logic                clk,
    input  logic                crst_n,
    cfg_frame_ctrl_if.slave     chain,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                cfg_valid,
    output logic                cfg_err,
    output logic                busy
);

    localparam int unsigned CNT_W = cnt_width(ID_WIDTH, CFG_SIZE);

    cfg_state_e       state;
    logic [CNT_W-1:0] cnt;
    cfg_mode_e        mode;

    cfg_frame_fsm #(
        .CFG_SIZE (CFG_SIZE),
        .ID_WIDTH (ID_WIDTH),
        .ID       (ID),
        .BCAST_EN (BCAST_EN)
    ) u_fsm (
        .clk    (clk),
        .crst_n (crst_n),
        .start  (chain.cfg_in_start),
        .bit_in (chain.cfg_bit_in),
        .state  (state),
        .cnt    (cnt),
        .mode   (mode)
    );

    logic [CFG_SIZE-1:0] shadow_q, shadow_d;
    logic [CFG_SIZE-1:0] cfg_q, cfg_d;
    logic                par_q, par_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                start_out_q;
    logic                bit_out_q, bit_out_d;
    logic [CFG_SIZE-1:0] rb_word;

    logic wr_pay, rd_pay, wr_par, rd_par;

    // A start in payload/parity aborts the frame, so it suppresses every frame action.
    assign wr_pay = (state == StPayload) && (mode == ModeWrite) && !chain.cfg_in_start;
    assign rd_pay = (state == StPayload) && (mode == ModeRead)  && !chain.cfg_in_start;
    assign wr_par = (state == StParity)  && (mode == ModeWrite) && !chain.cfg_in_start;
    assign rd_par = (state == StParity)  && (mode == ModeRead)  && !chain.cfg_in_start;

    assign rb_word = cfg_q >> cnt;

    always_comb begin
        shadow_d  = shadow_q;
        par_d     = par_q;
        cfg_d     = cfg_q;
        valid_d   = valid_q;
        err_d     = err_q;
        bit_out_d = chain.cfg_bit_in;
        if (chain.cfg_in_start) begin
            shadow_d = '0;
            par_d    = 1'b0;
        end
        if (wr_pay) begin
            shadow_d = {chain.cfg_bit_in, shadow_q[CFG_SIZE-1:1]};
            par_d    = par_q ^ chain.cfg_bit_in;
        end
        if (wr_par) begin
            if (chain.cfg_bit_in == par_q) begin
                cfg_d   = shadow_q;
                valid_d = 1'b1;
                err_d   = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (rd_pay) begin
            bit_out_d = rb_word[0];
        end
        if (rd_par) begin
            bit_out_d = ^cfg_q;
        end
    end

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            shadow_q    <= '0;
            par_q       <= 1'b0;
            cfg_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            start_out_q <= 1'b0;
            bit_out_q   <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            par_q       <= par_d;
            cfg_q       <= cfg_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            start_out_q <= chain.cfg_in_start;
            bit_out_q   <= bit_out_d;
        end
    end

    assign chain.cfg_out_start = start_out_q;
    assign chain.cfg_bit_out   = bit_out_q;
    assign cfg                 = cfg_q;
    assign cfg_valid           = valid_q;
    assign cfg_err             = err_q;
    assign busy                = (state != StIdle);

endmodule

// File: tb/tb_cfg_frame_ctrl.sv
// tb_cfg_frame_ctrl: directed frames against a frame-level model of one tile
// (CFG_SIZE=16, ID_WIDTH=3, ID=5, broadcast enabled).
module tb_cfg_frame_ctrl;

    localparam int CS  = 16;
    localparam int IDW = 3;
    localparam int DID = 5;

    logic          clk = 1'b0;
    logic          crst_n = 1'b0;
    logic [CS-1:0] cfg;
    logic          cfg_valid;
    logic          cfg_err;
    logic          busy;

    cfg_frame_ctrl_if chain();

    cfg_frame_ctrl #(
        .CFG_SIZE (CS),
        .ID_WIDTH (IDW),
        .ID       (DID),
        .BCAST_EN (1'b1)
    ) dut (
        .clk       (clk),
        .crst_n    (crst_n),
        .chain     (chain),
        .cfg       (cfg),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Frame-level model: m_pos is the index of the next frame bit after the start, -1 when idle.
    int            m_pos;
    int            m_addr;
    bit            m_op;
    logic [CS-1:0] m_pay;
    logic [CS-1:0] m_cfg;
    bit            m_valid;
    bit            m_err;
    bit            m_sbo;
    bit            m_bo;

    logic [CS-1:0] rb;
    logic          rb_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos   = -1;
        m_addr  = 0;
        m_op    = 1'b0;
        m_pay   = '0;
        m_cfg   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_sbo   = 1'b0;
        m_bo    = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b);
        bit wr_t;
        bit rd_t;
        int k;
        if (!crst_n) return;
        m_sbo = s;
        m_bo  = b;
        if (s) begin
            m_pos  = 0;
            m_addr = 0;
            m_op   = 1'b0;
            m_pay  = '0;
            return;
        end
        if (m_pos < 0) return;
        wr_t = (m_op == 1'b0) && (m_addr == DID || m_addr == 0);
        rd_t = (m_op == 1'b1) && (m_addr == DID);
        if (m_pos < IDW) begin
            m_addr += int'(b) << m_pos;
        end else if (m_pos == IDW) begin
            m_op = b;
        end else if (m_pos < IDW + 1 + CS) begin
            k = m_pos - IDW - 1;
            if (wr_t) m_pay[k] = b;
            if (rd_t) m_bo = m_cfg[k];
        end else begin
            if (wr_t) begin
                if ((^m_pay) == b) begin
                    m_cfg   = m_pay;
                    m_valid = 1'b1;
                    m_err   = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (rd_t) m_bo = ^m_cfg;
        end
        m_pos++;
        if (m_pos > IDW + 1 + CS) m_pos = -1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cfg", 32'(cfg), 32'(m_cfg));
            chk("cfg_valid", 32'(cfg_valid), 32'(m_valid));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_pos >= 0));
            chk("cfg_out_start", 32'(chain.cfg_out_start), 32'(m_sbo));
            chk("cfg_bit_out", 32'(chain.cfg_bit_out), 32'(m_bo));
        end
    end

    // One frame bit per call: drive, let the edge take it, step the model, settle.
    task automatic cyc(input logic s, input logic b);
        chain.cfg_in_start = s;
        chain.cfg_bit_in   = b;
        @(posedge clk);
        model_step(s, b);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    // cut >= 0 stops the frame before payload bit 'cut' is sent.
    task automatic frame(input logic [IDW-1:0] addr, input logic op, input logic [CS-1:0] pay,
                         input logic par, input int cut);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < IDW; i++) cyc(1'b0, addr[i]);
        cyc(1'b0, op);
        for (int k = 0; k < CS; k++) begin
            if (k == cut) return;
            cyc(1'b0, pay[k]);
            rb[k] = chain.cfg_bit_out;
        end
        cyc(1'b0, par);
        rb_par = chain.cfg_bit_out;
    endtask

    initial begin
        chain.cfg_in_start = 1'b0;
        chain.cfg_bit_in   = 1'b0;
        crst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cfg", 32'(cfg), 32'h0);
        chk("rst_valid", 32'(cfg_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        crst_n = 1'b1;
        idle(2);

        // good write to this tile
        frame(3'd5, 1'b0, 16'hA5C3, 1'b0, -1);
        chk("w_good_cfg", 32'(cfg), 32'hA5C3);
        chk("w_good_valid", 32'(cfg_valid), 32'h1);
        chk("w_good_err", 32'(cfg_err), 32'h0);
        idle(1);

        // bad parity
        frame(3'd5, 1'b0, 16'h0001, 1'b0, -1);
        chk("w_bad_cfg", 32'(cfg), 32'hA5C3);
        chk("w_bad_err", 32'(cfg_err), 32'h1);

        // other tile: pass-through only
        frame(3'd3, 1'b0, 16'hFFFF, 1'b0, -1);
        chk("w_other_cfg", 32'(cfg), 32'hA5C3);
        chk("w_other_fwd", 32'(rb), 32'hFFFF);

        // broadcast write, clears the error
        frame(3'd0, 1'b0, 16'h00FF, 1'b0, -1);
        chk("w_bcast_cfg", 32'(cfg), 32'h00FF);
        chk("w_bcast_err", 32'(cfg_err), 32'h0);

        // back-to-back frame, no idle gap
        frame(3'd5, 1'b0, 16'hA5C3, 1'b0, -1);
        chk("w_b2b_cfg", 32'(cfg), 32'hA5C3);

        // readback
        frame(3'd5, 1'b1, 16'h0000, 1'b0, -1);
        chk("rd_data", 32'(rb), 32'hA5C3);
        chk("rd_par", 32'(rb_par), 32'h0);
        chk("rd_cfg", 32'(cfg), 32'hA5C3);

        // broadcast readback is ignored
        frame(3'd0, 1'b1, 16'h5555, 1'b1, -1);
        chk("rd_bcast_fwd", 32'(rb), 32'h5555);
        chk("rd_bcast_par", 32'(rb_par), 32'h1);
        idle(1);

        // abort at payload bit 8, then a full frame
        frame(3'd5, 1'b0, 16'hFFFF, 1'b0, 8);
        chk("abort_cfg", 32'(cfg), 32'hA5C3);
        frame(3'd5, 1'b0, 16'h1234, 1'b1, -1);
        chk("restart_cfg", 32'(cfg), 32'h1234);
        chk("restart_err", 32'(cfg_err), 32'h0);
        idle(1);

        // reset mid-payload
        frame(3'd5, 1'b0, 16'hFFFF, 1'b0, 5);
        crst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_cfg", 32'(cfg), 32'h0);
        chk("mid_rst_valid", 32'(cfg_valid), 32'h0);
        chk("mid_rst_err", 32'(cfg_err), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_start", 32'(chain.cfg_out_start), 32'h0);
        chk("mid_rst_bit", 32'(chain.cfg_bit_out), 32'h0);
        chain.cfg_in_start = 1'b0;
        chain.cfg_bit_in   = 1'b0;
        @(posedge clk);
        #2;
        crst_n = 1'b1;
        idle(1);
        frame(3'd5, 1'b0, 16'h5A5A, 1'b0, -1);
        chk("post_rst_cfg", 32'(cfg), 32'h5A5A);
        chk("post_rst_valid", 32'(cfg_valid), 32'h1);
        idle(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
